systolic_feeder: RTL and testbench
==================================

Name: systolic_feeder

Overview:
- Input skew stage directly upstream of the SYS_ARRAY_SIZE x SYS_ARRAY_SIZE PE array.
- Accepts one column of N operands per beat over a valid/ready handshake and delays lane i by i extra steps, producing the diagonal wavefront the array needs.
- Tags each lane's final element with matrix_data_t.last and issues a step strobe that advances the array.
- One instance per operand matrix (A rows, B columns).

Parameters:
- N, default SYS_ARRAY_SIZE (2): number of lanes (array dimension).
- DATA_WIDTH, default DATA_WIDTH (8): operand width.
- K_WIDTH, default 8: width of the beat-count (inner dimension) field.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  begin a new operand stream.
- k_len_i  in  K_WIDTH  beats in the stream; sampled on accepted start.
- in_valid_i  in  1  input column valid.
- in_ready_o  out  1  feeder accepts a column.
- in_data_i  in  N*DATA_WIDTH  column; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_data_o  out  N x matrix_data_t  per-lane operand plus last flag to PE edge.
- step_o  out  1  out_data_o holds a new wavefront; the array advances this cycle.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle pulse when the skew is fully drained.

Behaviour:
- Reset (async, rst_ni=0):
  - State goes to IDLE.
  - All delay stages and out_data_o clear to 0, including last=0.
  - in_ready_o, step_o, busy_o and done_o clear to 0.
  - Beat counter clears to 0.
  - Reset mid-stream abandons the stream. No done_o is issued.
- FSM IDLE -> LOAD -> FLUSH -> IDLE:
  - IDLE:
    - start_i=1 with k_len_i>0: latch k_len, clear beat counter, go to LOAD.
    - start_i=1 with k_len_i=0: go nowhere; pulse done_o the next cycle.
  - LOAD:
    - in_ready_o=1.
    - advance = in_valid_i; a handshake is in_valid_i & in_ready_o.
    - The beat counter increments per handshake.
    - The handshake with count==k_len-1 marks the beat last; then go to FLUSH. If N=1, go directly to IDLE and raise done with that beat's step.
  - FLUSH:
    - in_ready_o=0.
    - advance=1 every cycle for exactly N-1 cycles, inserting data=0 and last=0 at lane inputs.
    - Then return to IDLE.
- Skew pipeline:
  - Lane i is a shift register of i+1 stages; all stages shift only on advance.
  - On a non-advance cycle all stages hold their value.
  - The last bit travels with its data.
- Latency: a column accepted at advance k appears on lane i's out_data_o after advance k+i (one cycle after that advance).
- step_o: registered copy of advance, so it is high in the cycle out_data_o shows freshly shifted values.
- done_o: registered. High coincident with step_o of the final FLUSH advance, i.e. the cycle lane N-1 presents last=1.
- Ignored inputs:
  - start_i while busy_o=1 is ignored.
  - in_valid_i outside LOAD is ignored and in_data_i is dropped.
- No backpressure from the array: the PE array always consumes on step_o.
- Beat counter is K_WIDTH bits and never wraps, since it stops at k_len-1.

Optional Feature:
- Macro FEEDER_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt_o (K_WIDTH+8 bits), which counts cycles in LOAD with in_valid_i=0.
  - Cleared on an accepted start and on reset.
  - Saturates at all-ones.
  - Holds its value after done.
- When not defined: the port and counter do not exist; the rest of the behaviour is unchanged.

Decomposition:
- Package common_pkg additions:
  - localparam FEEDER_K_WIDTH=8.
  - typedef logic[FEEDER_K_WIDTH-1:0] klen_t.
  - typedef enum logic[1:0] {FD_IDLE, FD_LOAD, FD_FLUSH} feeder_state_t.
- Reuse matrix_data_t from common_pkg.
- One sub-module: skew_delay_line.
  - Parameter DEPTH.
  - Enable-gated shift register of matrix_data_t, async active-low clear.
  - Instantiated once per lane with DEPTH=i+1.

Test Plan:
- N=2, start k_len=3, columns (1,2),(3,4),(5,6) valid every cycle:
  - Lane0 shows 1,3,5(last) on three consecutive step_o.
  - Lane1 shows 0,2,4,6(last).
  - done_o goes high with lane1=6 last, 4 step_o pulses total.
- Same stream with in_valid_i low for 2 cycles between beats 1 and 2:
  - Outputs hold and step_o=0 during the gap.
  - Output sequence is identical to the first test.
  - With FEEDER_STALL_CNT_EN, stall_cnt_o=2.
- start with k_len=0 -> done_o pulses the next cycle, busy_o stays 0, and no step_o is issued.
- start_i reasserted during LOAD with k_len_i=9 -> ignored; the stream still ends after the original 3 beats.
- rst_ni low during FLUSH:
  - All outputs are 0 immediately (async) and no done_o is issued.
  - A fresh start then runs normally.
- in_valid_i=1 while IDLE with data 0xFF -> in_ready_o=0, no step_o, and outputs stay 0.

Source files
------------

// File: rtl/common_pkg.sv
// Shared types for the systolic array datapath: array geometry, the per-lane
// operand record handed to the PE edge, and the input-feeder FSM encoding.
package common_pkg;

   localparam int SYS_ARRAY_SIZE = 2;
   localparam int DATA_WIDTH     = 8;

   // One operand travelling into the array, tagged with end-of-stream.
   typedef struct packed {
      logic                  last;
      logic [DATA_WIDTH-1:0] data;
   } matrix_data_t;

   localparam int FEEDER_K_WIDTH = 8;

   typedef logic [FEEDER_K_WIDTH-1:0] klen_t;

   typedef enum logic [1:0] {
      FD_IDLE,
      FD_LOAD,
      FD_FLUSH
   } feeder_state_t;

endpackage

// File: rtl/skew_delay_line.sv
// Enable-gated shift register of matrix_data_t, DEPTH stages deep.
// The output is the oldest stage; all stages hold while en_i is low.
module skew_delay_line
   import common_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         en_i,
   input  matrix_data_t din_i,
   output matrix_data_t dout_o
);

   matrix_data_t stage_reg [DEPTH];

   // Shift the whole line by one position on each enabled cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int s = 0; s < DEPTH; s++) begin
            stage_reg[s] <= '0;
         end
      end else if (en_i) begin
         stage_reg[0] <= din_i;
         for (int s = 1; s < DEPTH; s++) begin
            stage_reg[s] <= stage_reg[s-1];
         end
      end
   end

   assign dout_o = stage_reg[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Input skew stage in front of the PE array. Accepts one N-operand column per
// handshake, delays lane i by i extra steps to form the diagonal wavefront,
// tags each lane's final element with last and strobes step_o per advance.
// Optional build macro: FEEDER_STALL_CNT_EN adds stall_cnt_o, a saturating
// count of LOAD cycles without valid input.
module systolic_feeder
   import common_pkg::*;
#(
   parameter int N          = SYS_ARRAY_SIZE,
   parameter int DATA_WIDTH = common_pkg::DATA_WIDTH,
   parameter int K_WIDTH    = FEEDER_K_WIDTH
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    start_i,
   input  logic [K_WIDTH-1:0]      k_len_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [N*DATA_WIDTH-1:0] in_data_i,
   output matrix_data_t            out_data_o [N],
   output logic                    step_o,
   output logic                    busy_o,
   output logic                    done_o
`ifdef FEEDER_STALL_CNT_EN
   ,
   output logic [K_WIDTH+7:0]      stall_cnt_o
`endif
);

   // Flush counter only needs to reach N-2.
   localparam int FW = (N > 1) ? $clog2(N) : 1;

   feeder_state_t      state_reg, state_next;
   logic [K_WIDTH-1:0] k_len_reg, k_len_next;
   logic [K_WIDTH-1:0] beat_cnt_reg, beat_cnt_next;
   logic [FW-1:0]      flush_cnt_reg, flush_cnt_next;
   logic               step_reg, done_reg, done_next;
   logic               advance, load_beat, beat_last, ready;
   matrix_data_t       lane_in [N];

   // State and control registers; step/done are registered so they line up
   // with the freshly shifted outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg     <= FD_IDLE;
         k_len_reg     <= '0;
         beat_cnt_reg  <= '0;
         flush_cnt_reg <= '0;
         step_reg      <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         k_len_reg     <= k_len_next;
         beat_cnt_reg  <= beat_cnt_next;
         flush_cnt_reg <= flush_cnt_next;
         step_reg      <= advance;
         done_reg      <= done_next;
      end
   end

   // Next-state logic: advance is the shift enable for every lane.
   always_comb begin
      state_next     = state_reg;
      k_len_next     = k_len_reg;
      beat_cnt_next  = beat_cnt_reg;
      flush_cnt_next = flush_cnt_reg;
      done_next      = 1'b0;
      advance        = 1'b0;
      load_beat      = 1'b0;
      beat_last      = 1'b0;
      ready          = 1'b0;
      case (state_reg)
         FD_IDLE: begin
            if (start_i) begin
               if (k_len_i != '0) begin
                  k_len_next    = k_len_i;
                  beat_cnt_next = '0;
                  state_next    = FD_LOAD;
               end else begin
                  // Empty stream: nothing to skew, report completion at once.
                  done_next = 1'b1;
               end
            end
         end
         FD_LOAD: begin
            ready     = 1'b1;
            advance   = in_valid_i;
            load_beat = in_valid_i;
            if (in_valid_i) begin
               if (beat_cnt_reg == k_len_reg - K_WIDTH'(1)) begin
                  beat_last = 1'b1;
                  if (N == 1) begin
                     // Single lane has no skew to drain.
                     state_next = FD_IDLE;
                     done_next  = 1'b1;
                  end else begin
                     state_next     = FD_FLUSH;
                     flush_cnt_next = '0;
                  end
               end else begin
                  beat_cnt_next = beat_cnt_reg + K_WIDTH'(1);
               end
            end
         end
         FD_FLUSH: begin
            advance = 1'b1;
            if (flush_cnt_reg == FW'(N - 2)) begin
               state_next = FD_IDLE;
               done_next  = 1'b1;
            end else begin
               flush_cnt_next = flush_cnt_reg + FW'(1);
            end
         end
         default: state_next = FD_IDLE;
      endcase
   end

   // Per-lane input mux and delay line; lane i is i+1 stages deep. Outside a
   // handshake (flush) zeros with last=0 are pushed in.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_lane
         assign lane_in[gi].data = load_beat ? in_data_i[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
         assign lane_in[gi].last = load_beat & beat_last;

         skew_delay_line #(
            .DEPTH (gi + 1)
         ) u_delay (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .en_i   (advance),
            .din_i  (lane_in[gi]),
            .dout_o (out_data_o[gi])
         );
      end
   endgenerate

   assign in_ready_o = ready;
   assign step_o     = step_reg;
   assign busy_o     = (state_reg != FD_IDLE);
   assign done_o     = done_reg;

`ifdef FEEDER_STALL_CNT_EN
   logic [K_WIDTH+7:0] stall_cnt_reg;

   // Count starved LOAD cycles; restart on a new stream, saturate at all-ones.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_cnt_reg <= '0;
      end else if (state_reg == FD_IDLE && start_i) begin
         stall_cnt_reg <= '0;
      end else if (state_reg == FD_LOAD && !in_valid_i && !(&stall_cnt_reg)) begin
         stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
   end

   assign stall_cnt_o = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed, table-driven bench for systolic_feeder with N=2, k_len streams,
// input gaps, ignored restarts, empty streams and asynchronous reset.
module tb_systolic_feeder;
   import common_pkg::*;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic [7:0]         k_len = '0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [15:0]        in_data = '0;
   matrix_data_t       out_data [2];
   logic               step, busy, done;
`ifdef FEEDER_STALL_CNT_EN
   logic [15:0]        stall_cnt;
`endif

   int vec_cnt = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   systolic_feeder #(.N(2), .DATA_WIDTH(8), .K_WIDTH(8)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .start_i     (start),
      .k_len_i     (k_len),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_data_i   (in_data),
      .out_data_o  (out_data),
      .step_o      (step),
      .busy_o      (busy),
      .done_o      (done)
`ifdef FEEDER_STALL_CNT_EN
      ,
      .stall_cnt_o (stall_cnt)
`endif
   );

   typedef struct {
      logic       start;
      logic [7:0] k;
      logic       valid;
      logic [7:0] d0, d1;
      logic       step;
      logic [7:0] o0;
      logic       l0;
      logic [7:0] o1;
      logic       l1;
      logic       done, busy, ready;
   } vec_t;

   function automatic vec_t mk(int st, int k, int vl, int d0, int d1,
                               int sp, int o0, int l0, int o1, int l1,
                               int dn, int bz, int rd);
      vec_t v;
      v.start = st[0]; v.k = k[7:0]; v.valid = vl[0];
      v.d0 = d0[7:0]; v.d1 = d1[7:0];
      v.step = sp[0]; v.o0 = o0[7:0]; v.l0 = l0[0];
      v.o1 = o1[7:0]; v.l1 = l1[0];
      v.done = dn[0]; v.busy = bz[0]; v.ready = rd[0];
      return v;
   endfunction

   // Compare every DUT output against the expected fields of v.
   task automatic chk(input string tag, input vec_t v);
      vec_cnt++;
      if (step !== v.step || out_data[0].data !== v.o0 || out_data[0].last !== v.l0 ||
          out_data[1].data !== v.o1 || out_data[1].last !== v.l1 ||
          done !== v.done || busy !== v.busy || in_ready !== v.ready) begin
         miscompares++;
         $display("FAIL %s got step=%0b l0=%0h/%0b l1=%0h/%0b done=%0b busy=%0b rdy=%0b, expected step=%0b l0=%0h/%0b l1=%0h/%0b done=%0b busy=%0b rdy=%0b",
                  tag, step, out_data[0].data, out_data[0].last, out_data[1].data,
                  out_data[1].last, done, busy, in_ready, v.step, v.o0, v.l0,
                  v.o1, v.l1, v.done, v.busy, v.ready);
      end else begin
         $display("ok   %s step=%0b l0=%0h/%0b l1=%0h/%0b done=%0b busy=%0b rdy=%0b",
                  tag, step, out_data[0].data, out_data[0].last, out_data[1].data,
                  out_data[1].last, done, busy, in_ready);
      end
   endtask

   // Drive one row on the falling edge, check #1 after the following rising edge.
   task automatic apply(input vec_t v, input string tag);
      @(negedge clk);
      start    = v.start;
      k_len    = v.k;
      in_valid = v.valid;
      in_data  = {v.d1, v.d0};
      @(posedge clk);
      #1;
      chk(tag, v);
   endtask

   task automatic run_table(input vec_t tbl [$], input string name);
      foreach (tbl[i]) apply(tbl[i], $sformatf("%s[%0d]", name, i));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; k_len = '0; in_data = '0;
      #1;
      chk("reset_state", mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic chk_stall(input string tag, input int exp);
`ifdef FEEDER_STALL_CNT_EN
      vec_cnt++;
      if (stall_cnt !== 16'(exp)) begin
         miscompares++;
         $display("FAIL %s stall_cnt got %0d expected %0d", tag, stall_cnt, exp);
      end else begin
         $display("ok   %s stall_cnt=%0d", tag, stall_cnt);
      end
`endif
   endtask

   vec_t t1 [$];
   vec_t t2 [$];
   vec_t t3 [$];
   vec_t t4 [$];
   vec_t t5 [$];
   vec_t idle_rows [$];

   initial begin
      // Plain stream k=3 from reset: lane0 1,3,5L; lane1 0,2,4,6L; done with 6L.
      t1.push_back(mk(1,3,0,0,0,       0,0,0,0,0, 0,1,1));
      t1.push_back(mk(0,0,1,1,2,       1,1,0,0,0, 0,1,1));
      t1.push_back(mk(0,0,1,3,4,       1,3,0,2,0, 0,1,1));
      t1.push_back(mk(0,0,1,5,6,       1,5,1,4,0, 0,1,0));
      t1.push_back(mk(0,0,0,0,0,       1,0,0,6,1, 1,0,0));
      t1.push_back(mk(0,0,0,0,0,       0,0,0,6,1, 0,0,0));

      // Same stream with a two-cycle input gap; outputs hold, gap data dropped.
      t2.push_back(mk(1,3,0,0,0,       0,0,0,6,1, 0,1,1));
      t2.push_back(mk(0,0,1,1,2,       1,1,0,0,0, 0,1,1));
      t2.push_back(mk(0,0,0,255,255,   0,1,0,0,0, 0,1,1));
      t2.push_back(mk(0,0,0,255,255,   0,1,0,0,0, 0,1,1));
      t2.push_back(mk(0,0,1,3,4,       1,3,0,2,0, 0,1,1));
      t2.push_back(mk(0,0,1,5,6,       1,5,1,4,0, 0,1,0));
      t2.push_back(mk(0,0,0,0,0,       1,0,0,6,1, 1,0,0));
      t2.push_back(mk(0,0,0,0,0,       0,0,0,6,1, 0,0,0));

      // Restart with k=9 while busy is ignored; stream still ends after 3 beats.
      t4.push_back(mk(1,3,0,0,0,       0,0,0,6,1, 0,1,1));
      t4.push_back(mk(1,9,1,1,2,       1,1,0,0,0, 0,1,1));
      t4.push_back(mk(1,9,1,3,4,       1,3,0,2,0, 0,1,1));
      t4.push_back(mk(1,9,1,5,6,       1,5,1,4,0, 0,1,0));
      t4.push_back(mk(1,9,0,0,0,       1,0,0,6,1, 1,0,0));
      t4.push_back(mk(0,0,0,0,0,       0,0,0,6,1, 0,0,0));

      // Empty stream: done next cycle, never busy, no step.
      t3.push_back(mk(1,0,0,0,0,       0,0,0,6,1, 1,0,0));
      t3.push_back(mk(0,0,0,0,0,       0,0,0,6,1, 0,0,0));

      // Valid input while idle is not accepted.
      t5.push_back(mk(0,0,1,255,255,   0,0,0,0,0, 0,0,0));
      t5.push_back(mk(0,0,1,255,255,   0,0,0,0,0, 0,0,0));

      idle_rows.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0));
      idle_rows.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0));

      do_reset();
      run_table(t1, "basic");
      run_table(t2, "gap");
      chk_stall("gap_stall", 2);
      run_table(t4, "restart");
      chk_stall("restart_stall", 0);
      run_table(t3, "klen0");

      do_reset();
      run_table(t5, "idle_valid");

      // Reset while flushing: outputs clear at once and no done follows.
      for (int i = 0; i < 4; i++) apply(t1[i], $sformatf("pre_rst[%0d]", i));
      rst_n = 1'b0;
      #1;
      chk("rst_async", mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0));
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("rst_hold[%0d]", i), mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0));
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_table(idle_rows, "post_rst");
      run_table(t1, "fresh");

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
      $finish;
   end

   // Hard bound on simulation time.
   initial begin
      #100000;
      $display("FAIL watchdog timeout after %0t", $time);
      $fatal(1);
   end

endmodule
